// File: rtl/mpeg_cfg_seq_if.sv
// Host command channel for the mpeg2video register sequencer.
// The host drives the command; the sequencer returns ready, done and error.
interface mpeg_cfg_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        done;
    logic        timeout_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, done, timeout_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, done, timeout_err
    );
endinterface

// File: rtl/mpeg_cfg_seq.sv
// Register-programming sequencer for the mpeg2video decoder core.
// Runs INIT after reset, then serves INIT / FLUSH / SET_MODE host commands.
module mpeg_cfg_seq #(
    parameter logic [4:0]  CTRL_ADDR  = 5'd1,
    parameter logic [4:0]  INTR_ADDR  = 5'd3,
    parameter logic [4:0]  MODE_ADDR  = 5'd4,
    parameter logic [31:0] INIT_CTRL  = 32'h0000_0001,
    parameter logic [31:0] INTR_MASK  = 32'h0000_0000,
    parameter int unsigned FLUSH_BIT  = 1,
    parameter int unsigned WR_GAP     = 1,
    parameter int unsigned FLUSH_HOLD = 8,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic          sys_clk,
    input  logic          RESET_N,
    mpeg_cfg_seq_if.slave cmd,
    input  logic          busy,
    output logic [4:0]    reg_addr,
    output logic [31:0]   reg_dta_in,
    output logic          reg_wr_en,
    input  logic          stream_valid_in,
    output logic          stream_valid_out
);

    typedef enum logic [2:0] {
        IDLE, WRITE, GAP, DRAIN, HOLD, FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT, OP_FLUSH, OP_SET, OP_NOP
    } op_t;

    localparam logic [31:0] FLUSH_CTRL = INIT_CTRL | (32'd1 << FLUSH_BIT);

    state_t      state;
    op_t         op_q;
    logic [1:0]  step;
    logic [31:0] mode_q;
    logic        boot;
    logic        stream_en;
    logic        ready_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  gap_cnt;
    logic [7:0]  hold_cnt;
    logic [15:0] drain_cnt;
    logic        accept;

    assign accept           = cmd.cmd_valid & ready_q;
    assign cmd.cmd_ready    = ready_q;
    assign cmd.done         = done_q;
    assign cmd.timeout_err  = err_q;
    assign stream_valid_out = stream_valid_in & stream_en;

    function automatic logic [4:0] step_addr(op_t op, logic [1:0] s);
        if (op == OP_INIT)
            return (s == 2'd0) ? CTRL_ADDR :
                   (s == 2'd1) ? INTR_ADDR : MODE_ADDR;
        if (op == OP_SET)
            return MODE_ADDR;
        return CTRL_ADDR;
    endfunction

    function automatic logic [31:0] step_data(
        op_t op, logic [1:0] s, logic [31:0] m
    );
        if (op == OP_INIT)
            return (s == 2'd0) ? INIT_CTRL :
                   (s == 2'd1) ? INTR_MASK : m;
        if (op == OP_SET)
            return m;
        return (s == 2'd0) ? FLUSH_CTRL : INIT_CTRL;
    endfunction

    function automatic logic [1:0] last_step(op_t op);
        if (op == OP_INIT)
            return 2'd2;
        if (op == OP_FLUSH)
            return 2'd1;
        return 2'd0;
    endfunction

    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            op_q       <= OP_INIT;
            step       <= 2'd0;
            mode_q     <= 32'd0;
            boot       <= 1'b1;
            stream_en  <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            reg_wr_en  <= 1'b0;
            reg_addr   <= 5'd0;
            reg_dta_in <= 32'd0;
            gap_cnt    <= 4'd0;
            hold_cnt   <= 8'd0;
            drain_cnt  <= 16'd0;
        end else begin
            reg_wr_en <= 1'b0;
            done_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (boot) begin
                        boot       <= 1'b0;
                        op_q       <= OP_INIT;
                        step       <= 2'd0;
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= CTRL_ADDR;
                        reg_dta_in <= INIT_CTRL;
                        state      <= WRITE;
                    end else if (accept) begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        op_q    <= op_t'(cmd.cmd_op);
                        step    <= 2'd0;
                        unique case (1'b1)
                            (cmd.cmd_op == OP_INIT): begin
                                mode_q     <= cmd.cmd_data;
                                reg_wr_en  <= 1'b1;
                                reg_addr   <= CTRL_ADDR;
                                reg_dta_in <= INIT_CTRL;
                                state      <= WRITE;
                            end
                            (cmd.cmd_op == OP_SET): begin
                                mode_q     <= cmd.cmd_data;
                                reg_wr_en  <= 1'b1;
                                reg_addr   <= MODE_ADDR;
                                reg_dta_in <= cmd.cmd_data;
                                state      <= WRITE;
                            end
                            (cmd.cmd_op == OP_FLUSH): begin
                                stream_en <= 1'b0;
                                drain_cnt <= 16'd0;
                                state     <= DRAIN;
                            end
                            default: begin
                                done_q <= 1'b1;
                                state  <= FIN;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (op_q == OP_FLUSH && step == 2'd0) begin
                        hold_cnt <= 8'd0;
                        state    <= HOLD;
                    end else if (step == last_step(op_q)) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else if (WR_GAP == 0) begin
                        step       <= step + 2'd1;
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= step_addr(op_q, step + 2'd1);
                        reg_dta_in <= step_data(op_q, step + 2'd1, mode_q);
                    end else begin
                        gap_cnt <= 4'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'(WR_GAP - 1)) begin
                        step       <= step + 2'd1;
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= step_addr(op_q, step + 2'd1);
                        reg_dta_in <= step_data(op_q, step + 2'd1, mode_q);
                        state      <= WRITE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    // a stuck busy is treated as drained once the budget runs out
                    if (!busy || drain_cnt == TIMEOUT - 16'd1) begin
                        if (busy)
                            err_q <= 1'b1;
                        step       <= 2'd0;
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= CTRL_ADDR;
                        reg_dta_in <= FLUSH_CTRL;
                        state      <= WRITE;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'(FLUSH_HOLD - 1)) begin
                        step       <= 2'd1;
                        reg_wr_en  <= 1'b1;
                        reg_addr   <= CTRL_ADDR;
                        reg_dta_in <= INIT_CTRL;
                        state      <= WRITE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                FIN: begin
                    stream_en <= 1'b1;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpeg_cfg_seq.sv
// Randomized bench for mpeg_cfg_seq against a cycle-arithmetic model
// of the expected register writes, done pulses and stream gating.
module tb_mpeg_cfg_seq;

    localparam int GAPC = 1;
    localparam int HOLD = 8;
    localparam int TO   = 16;

    typedef struct packed {
        logic [31:0] c;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        busy;
    logic        svi;
    logic        svo;
    logic [4:0]  reg_addr;
    logic [31:0] reg_dta_in;
    logic        reg_wr_en;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lo_first;
    int lo_last;

    wr_t wq[$];
    int  dq[$];
    wr_t ew[$];
    int  e_done;
    bit  e_err;

    mpeg_cfg_seq_if ifc ();

    mpeg_cfg_seq #(
        .TIMEOUT(16'(TO))
    ) dut (
        .sys_clk         (clk),
        .RESET_N         (rst_n),
        .cmd             (ifc),
        .busy            (busy),
        .reg_addr        (reg_addr),
        .reg_dta_in      (reg_dta_in),
        .reg_wr_en       (reg_wr_en),
        .stream_valid_in (svi),
        .stream_valid_out(svo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en)
                wq.push_back({32'(cyc), reg_addr, reg_dta_in});
            if (ifc.done)
                dq.push_back(cyc);
            if (svi && !svo) begin
                if (lo_first < 0)
                    lo_first = cyc;
                lo_last = cyc;
            end
        end
    end

    function automatic wr_t mk(int c, logic [4:0] a, logic [31:0] d);
        return {32'(c), a, d};
    endfunction

    // expected writes and done cycle, relative to the acceptance cycle
    function automatic void model(int op, int acc, logic [31:0] data, int bcy);
        int w;
        ew.delete();
        e_err = 1'b0;
        case (op)
            0: begin
                w = acc + 1;
                ew.push_back(mk(w, 5'd1, 32'h1));
                ew.push_back(mk(w + GAPC + 1, 5'd3, 32'h0));
                ew.push_back(mk(w + 2 * GAPC + 2, 5'd4, data));
                e_done = w + 2 * GAPC + 3;
            end
            1: begin
                w = (bcy < TO) ? acc + bcy + 2 : acc + TO + 1;
                e_err = (bcy >= TO);
                ew.push_back(mk(w, 5'd1, 32'h3));
                ew.push_back(mk(w + HOLD + 1, 5'd1, 32'h1));
                e_done = w + HOLD + 2;
            end
            2: begin
                ew.push_back(mk(acc + 1, 5'd4, data));
                e_done = acc + 2;
            end
            default: e_done = acc + 1;
        endcase
    endfunction

    task automatic run_cmd(input int op, input logic [31:0] data,
                           input int bcy, output int acc);
        int n;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'(op);
        ifc.cmd_data  = data;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!ifc.cmd_ready) begin
            failures++;
            $display("FAIL ready_wait got cmd_ready=0 req 1 after %0d cycles", n);
        end
        acc = cyc;
        wq.delete();
        dq.delete();
        lo_first = -1;
        lo_last = -1;
        busy = (bcy > 0);
        n = 0;
        while (dq.size() == 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
            ifc.cmd_valid = 1'b0;
            ifc.cmd_op    = 2'($urandom);
            ifc.cmd_data  = $urandom;
            if (cyc - acc > bcy)
                busy = 1'b0;
        end
        busy = 1'b0;
        checks++;
        if (dq.size() == 0) begin
            failures++;
            $display("FAIL done_wait got no done pulse req one within 200 cycles");
        end
    endtask

    task automatic test_reset();
        int r;
        svi = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({reg_wr_en, ifc.cmd_ready, ifc.done, ifc.timeout_err, svo} !== 5'b0
            || reg_addr !== 5'd0 || reg_dta_in !== 32'd0) begin
            failures++;
            $display("FAIL reset_outs got wr=%b rdy=%b done=%b err=%b svo=%b a=%h d=%h req all 0",
                     reg_wr_en, ifc.cmd_ready, ifc.done, ifc.timeout_err, svo,
                     reg_addr, reg_dta_in);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        r = cyc;
        wq.delete();
        dq.delete();
        lo_first = -1;
        lo_last = -1;
        model(0, r, 32'd0, 0);
        while (cyc < r + 6) begin
            @(negedge clk); #1;
        end
        checks++;
        if (ifc.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL boot_ready_c6 got %b req 0", ifc.cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (ifc.cmd_ready !== 1'b1 || svo !== 1'b1) begin
            failures++;
            $display("FAIL boot_c7 got rdy=%b svo=%b req 1 1", ifc.cmd_ready, svo);
        end
        checks++;
        if (lo_first != r + 1 || lo_last != r + 6) begin
            failures++;
            $display("FAIL boot_stream got gated %0d..%0d req %0d..%0d",
                     lo_first - r, lo_last - r, 1, 6);
        end
        checks++;
        if (wq.size() != ew.size()) begin
            failures++;
            $display("FAIL boot_nwr got %0d req %0d", wq.size(), ew.size());
        end
        foreach (ew[i]) begin
            if (i < wq.size()) begin
                checks++;
                if (wq[i] !== ew[i]) begin
                    failures++;
                    $display("FAIL boot_wr%0d got c%0d a=%h d=%h req c%0d a=%h d=%h",
                             i, wq[i].c - r, wq[i].a, wq[i].d,
                             ew[i].c - r, ew[i].a, ew[i].d);
                end
            end
        end
        checks++;
        if (dq.size() != 1 || dq[0] != e_done) begin
            failures++;
            $display("FAIL boot_done got n=%0d c%0d req c%0d", dq.size(),
                     (dq.size() > 0) ? dq[0] - r : -1, e_done - r);
        end
    endtask

    task automatic test_set_init();
        int acc;
        int op;
        logic [31:0] dat;
        for (int k = 0; k < 2; k++) begin
            op  = (k == 0) ? 2 : 0;
            dat = 32'h25;
            busy = 1'b0;
            run_cmd(op, dat, $urandom_range(0, 4), acc);
            model(op, acc, dat, 0);
            checks++;
            if (wq.size() != ew.size()) begin
                failures++;
                $display("FAIL setinit%0d_nwr got %0d req %0d", k, wq.size(), ew.size());
            end
            foreach (ew[i]) begin
                if (i < wq.size()) begin
                    checks++;
                    if (wq[i] !== ew[i]) begin
                        failures++;
                        $display("FAIL setinit%0d_wr%0d got c%0d a=%h d=%h req c%0d a=%h d=%h",
                                 k, i, wq[i].c - acc, wq[i].a, wq[i].d,
                                 ew[i].c - acc, ew[i].a, ew[i].d);
                    end
                end
            end
            checks++;
            if (dq.size() != 1 || dq[0] != e_done) begin
                failures++;
                $display("FAIL setinit%0d_done got c%0d req c%0d", k,
                         (dq.size() > 0) ? dq[0] - acc : -1, e_done - acc);
            end
            @(negedge clk); #1;
            checks++;
            if (ifc.cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL setinit%0d_ready got %b req 1", k, ifc.cmd_ready);
            end
        end
    endtask

    task automatic test_flush(input int bcy);
        int acc;
        svi = 1'b1;
        run_cmd(1, $urandom, bcy, acc);
        model(1, acc, 32'd0, bcy);
        checks++;
        if (wq.size() != ew.size()) begin
            failures++;
            $display("FAIL flush%0d_nwr got %0d req %0d", bcy, wq.size(), ew.size());
        end
        foreach (ew[i]) begin
            if (i < wq.size()) begin
                checks++;
                if (wq[i] !== ew[i]) begin
                    failures++;
                    $display("FAIL flush%0d_wr%0d got c%0d a=%h d=%h req c%0d a=%h d=%h",
                             bcy, i, wq[i].c - acc, wq[i].a, wq[i].d,
                             ew[i].c - acc, ew[i].a, ew[i].d);
                end
            end
        end
        checks++;
        if (dq.size() != 1 || dq[0] != e_done) begin
            failures++;
            $display("FAIL flush%0d_done got c%0d req c%0d", bcy,
                     (dq.size() > 0) ? dq[0] - acc : -1, e_done - acc);
        end
        checks++;
        if (ifc.timeout_err !== e_err) begin
            failures++;
            $display("FAIL flush%0d_err got %b req %b", bcy, ifc.timeout_err, e_err);
        end
        checks++;
        if (lo_first != acc + 1 || lo_last != e_done) begin
            failures++;
            $display("FAIL flush%0d_stream got gated %0d..%0d req %0d..%0d", bcy,
                     lo_first - acc, lo_last - acc, 1, e_done - acc);
        end
        @(negedge clk); #1;
        checks++;
        if (ifc.cmd_ready !== 1'b1 || svo !== 1'b1) begin
            failures++;
            $display("FAIL flush%0d_after got rdy=%b svo=%b req 1 1", bcy,
                     ifc.cmd_ready, svo);
        end
    endtask

    task automatic test_nop();
        int acc;
        run_cmd(3, $urandom, 0, acc);
        checks++;
        if (wq.size() != 0 || dq.size() != 1 || dq[0] != acc + 1) begin
            failures++;
            $display("FAIL nop got nwr=%0d done c%0d req nwr=0 done c1", wq.size(),
                     (dq.size() > 0) ? dq[0] - acc : -1);
        end
        checks++;
        if (ifc.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL nop_err_clear got %b req 0", ifc.timeout_err);
        end
        svi = 1'b0;
        #1;
        checks++;
        if (svo !== 1'b0) begin
            failures++;
            $display("FAIL stream_comb0 got %b req 0", svo);
        end
        svi = 1'b1;
        #1;
        checks++;
        if (svo !== 1'b1) begin
            failures++;
            $display("FAIL stream_comb1 got %b req 1", svo);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int n;
        int d1;
        wr_t ew1[$];
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'd0;
        ifc.cmd_data  = a;
        acc = cyc;
        wq.delete();
        dq.delete();
        model(0, acc, a, 0);
        ew1 = ew;
        d1 = e_done;
        model(2, d1 + 1, b, 0);
        ew = {ew1, ew};
        n = 0;
        while (dq.size() < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
            ifc.cmd_op   = 2'd2;
            ifc.cmd_data = b;
            if (cyc == d1 + 2)
                ifc.cmd_valid = 1'b0;
        end
        ifc.cmd_valid = 1'b0;
        checks++;
        if (wq.size() != ew.size()) begin
            failures++;
            $display("FAIL b2b_nwr got %0d req %0d", wq.size(), ew.size());
        end
        foreach (ew[i]) begin
            if (i < wq.size()) begin
                checks++;
                if (wq[i] !== ew[i]) begin
                    failures++;
                    $display("FAIL b2b_wr%0d got c%0d a=%h d=%h req c%0d a=%h d=%h",
                             i, wq[i].c - acc, wq[i].a, wq[i].d,
                             ew[i].c - acc, ew[i].a, ew[i].d);
                end
            end
        end
        checks++;
        if (dq.size() != 2 || dq[0] != d1 || dq[1] != e_done) begin
            failures++;
            $display("FAIL b2b_done got n=%0d first c%0d req c%0d,c%0d", dq.size(),
                     (dq.size() > 0) ? dq[0] - acc : -1, d1 - acc, e_done - acc);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        int acc;
        int op;
        int bcy;
        logic [31:0] dat;
        for (int k = 0; k < 10; k++) begin
            op  = $urandom_range(0, 3);
            dat = $urandom;
            bcy = $urandom_range(0, 20);
            svi = 1'($urandom);
            run_cmd(op, dat, bcy, acc);
            model(op, acc, dat, bcy);
            checks++;
            if (wq.size() != ew.size()) begin
                failures++;
                $display("FAIL rnd%0d_op%0d_nwr got %0d req %0d", k, op, wq.size(), ew.size());
            end
            foreach (ew[i]) begin
                if (i < wq.size()) begin
                    checks++;
                    if (wq[i] !== ew[i]) begin
                        failures++;
                        $display("FAIL rnd%0d_op%0d_wr%0d got c%0d a=%h d=%h req c%0d a=%h d=%h",
                                 k, op, i, wq[i].c - acc, wq[i].a, wq[i].d,
                                 ew[i].c - acc, ew[i].a, ew[i].d);
                    end
                end
            end
            checks++;
            if (dq.size() != 1 || dq[0] != e_done || ifc.timeout_err !== e_err) begin
                failures++;
                $display("FAIL rnd%0d_op%0d_done got c%0d err=%b req c%0d err=%b", k, op,
                         (dq.size() > 0) ? dq[0] - acc : -1, ifc.timeout_err,
                         e_done - acc, e_err);
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int acc;
        int n;
        svi = 1'b1;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'd1;
        acc = cyc;
        while (cyc < acc + 5) begin
            @(negedge clk); #1;
            ifc.cmd_valid = 1'b0;
        end
        checks++;
        if (reg_wr_en !== 1'b0 || reg_addr !== 5'd1 || reg_dta_in !== 32'h3) begin
            failures++;
            $display("FAIL mid_hold got wr=%b a=%h d=%h req 0 01 00000003",
                     reg_wr_en, reg_addr, reg_dta_in);
        end
        test_reset();
    endtask

    initial begin
        busy = 1'b0;
        svi = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 2'd0;
        ifc.cmd_data = 32'd0;
        lo_first = -1;
        lo_last = -1;
        test_reset();
        test_set_init();
        test_flush(10);
        test_flush(0);
        test_flush(1000);
        test_nop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
